// File: rtl/controle_irrigacao.sv
`default_nettype none
// ============================================================================
// Module   : controle_irrigacao
// Purpose  : Irrigation sequencer that loads a BCD MM:SS countdown, decrements
//            it once per second and drives the sprinkler/drip valves.
// Revision : 1.0 - initial release
// ============================================================================
module controle_irrigacao #(
    parameter int         MIN_ASPERSAO    = 5,
    parameter int         MIN_GOTEJAMENTO = 10,
    parameter int         MIN_ESPECIFICO  = 2,
    parameter logic [2:0] NIVEL_MIN_ASP   = 3'd2
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       umSegundo,
    input  logic       buttonPulse,
    input  logic       aspersao,
    input  logic       gotejamento,
    input  logic       casoEspecifico,
    input  logic [2:0] nivelDagua,
    output logic [3:0] Us,
    output logic [3:0] Ds,
    output logic [3:0] Um,
    output logic [3:0] Dm,
    output logic       valvulaAspersao,
    output logic       valvulaGotejamento,
    output logic       ativo,
    output logic       fim,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        ERRO     = 2'd2
    } state_t;

    localparam logic [3:0] ASP_DEZ = 4'(MIN_ASPERSAO / 10);
    localparam logic [3:0] ASP_UNI = 4'(MIN_ASPERSAO % 10);
    localparam logic [3:0] GOT_DEZ = 4'(MIN_GOTEJAMENTO / 10);
    localparam logic [3:0] GOT_UNI = 4'(MIN_GOTEJAMENTO % 10);
    localparam logic [3:0] ESP_DEZ = 4'(MIN_ESPECIFICO / 10);
    localparam logic [3:0] ESP_UNI = 4'(MIN_ESPECIFICO % 10);

    state_t     state, state_nxt;
    logic       modo_asp, modo_asp_nxt;
    logic [3:0] us_nxt, ds_nxt, um_nxt, dm_nxt;
    logic       fim_nxt;
    logic       falta_agua;
    logic       contador_zero;

    // Level fault uses the mode latched at start, not the live request inputs.
    assign falta_agua    = (nivelDagua == 3'd0) || (modo_asp && (nivelDagua < NIVEL_MIN_ASP));
    assign contador_zero = ({Dm, Um, Ds, Us} == 16'h0000);

    always_comb begin
        state_nxt    = state;
        modo_asp_nxt = modo_asp;
        us_nxt       = Us;
        ds_nxt       = Ds;
        um_nxt       = Um;
        dm_nxt       = Dm;
        fim_nxt      = 1'b0;

        case (state)
            OCIOSO: begin
                if (buttonPulse && (aspersao != gotejamento)) begin
                    if ((nivelDagua == 3'd0) || (aspersao && (nivelDagua < NIVEL_MIN_ASP))) begin
                        state_nxt = ERRO;
                    end else begin
                        state_nxt    = CONTANDO;
                        modo_asp_nxt = aspersao;
                        us_nxt       = 4'd0;
                        ds_nxt       = 4'd0;
                        if (casoEspecifico) begin
                            dm_nxt = ESP_DEZ;
                            um_nxt = ESP_UNI;
                        end else if (aspersao) begin
                            dm_nxt = ASP_DEZ;
                            um_nxt = ASP_UNI;
                        end else begin
                            dm_nxt = GOT_DEZ;
                            um_nxt = GOT_UNI;
                        end
                    end
                end
            end

            CONTANDO: begin
                if (falta_agua) begin
                    state_nxt = ERRO;
                end else if (buttonPulse) begin
                    state_nxt = OCIOSO;
                end else if (umSegundo) begin
                    if (contador_zero) begin
                        state_nxt = OCIOSO;
                    end else begin
                        if (Us != 4'd0) begin
                            us_nxt = Us - 4'd1;
                        end else begin
                            us_nxt = 4'd9;
                            if (Ds != 4'd0) begin
                                ds_nxt = Ds - 4'd1;
                            end else begin
                                ds_nxt = 4'd5;
                                if (Um != 4'd0) begin
                                    um_nxt = Um - 4'd1;
                                end else begin
                                    um_nxt = 4'd9;
                                    dm_nxt = Dm - 4'd1;
                                end
                            end
                        end
                        if ({dm_nxt, um_nxt, ds_nxt, us_nxt} == 16'h0000) begin
                            state_nxt = OCIOSO;
                            fim_nxt   = 1'b1;
                        end
                    end
                end
            end

            ERRO: begin
                if (buttonPulse && (nivelDagua != 3'd0)) begin
                    state_nxt = OCIOSO;
                    us_nxt    = 4'd0;
                    ds_nxt    = 4'd0;
                    um_nxt    = 4'd0;
                    dm_nxt    = 4'd0;
                end
            end

            default: state_nxt = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state              <= OCIOSO;
            modo_asp           <= 1'b0;
            Us                 <= 4'd0;
            Ds                 <= 4'd0;
            Um                 <= 4'd0;
            Dm                 <= 4'd0;
            valvulaAspersao    <= 1'b0;
            valvulaGotejamento <= 1'b0;
            ativo              <= 1'b0;
            fim                <= 1'b0;
            erro               <= 1'b0;
        end else begin
            state              <= state_nxt;
            modo_asp           <= modo_asp_nxt;
            Us                 <= us_nxt;
            Ds                 <= ds_nxt;
            Um                 <= um_nxt;
            Dm                 <= dm_nxt;
            valvulaAspersao    <= (state_nxt == CONTANDO) && modo_asp_nxt;
            valvulaGotejamento <= (state_nxt == CONTANDO) && !modo_asp_nxt;
            ativo              <= (state_nxt == CONTANDO);
            fim                <= fim_nxt;
            erro               <= (state_nxt == ERRO);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controle_irrigacao.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_irrigacao
// Purpose  : Directed self-checking bench for the irrigation sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_irrigacao;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       umSegundo = 1'b0;
    logic       buttonPulse = 1'b0;
    logic       aspersao = 1'b0;
    logic       gotejamento = 1'b0;
    logic       casoEspecifico = 1'b0;
    logic [2:0] nivelDagua = 3'd0;
    logic [3:0] Us, Ds, Um, Dm;
    logic       valvulaAspersao, valvulaGotejamento, ativo, fim, erro;

    int tests_run = 0;
    int tests_failed = 0;

    wire [15:0] disp = {Dm, Um, Ds, Us};
    wire [4:0]  flags = {valvulaAspersao, valvulaGotejamento, ativo, fim, erro};

    controle_irrigacao dut (
        .clock              (clock),
        .resetN             (resetN),
        .umSegundo          (umSegundo),
        .buttonPulse        (buttonPulse),
        .aspersao           (aspersao),
        .gotejamento        (gotejamento),
        .casoEspecifico     (casoEspecifico),
        .nivelDagua         (nivelDagua),
        .Us                 (Us),
        .Ds                 (Ds),
        .Um                 (Um),
        .Dm                 (Dm),
        .valvulaAspersao    (valvulaAspersao),
        .valvulaGotejamento (valvulaGotejamento),
        .ativo              (ativo),
        .fim                (fim),
        .erro               (erro)
    );

    always #5 clock = ~clock;

    // One-cycle pulse on the chosen inputs; returns at the negedge after the update.
    task automatic pulse(input logic btn, input logic tick);
        @(negedge clock);
        buttonPulse = btn;
        umSegundo   = tick;
        @(negedge clock);
        buttonPulse = 1'b0;
        umSegundo   = 1'b0;
    endtask

    task automatic ticks(input int n, output int fims);
        fims = 0;
        for (int i = 0; i < n; i++) begin
            pulse(1'b0, 1'b1);
            if (fim) fims++;
        end
    endtask

    task automatic test_reset();
        int f;
        tests_run++;
        if ({disp, flags} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got disp=%h flags=%b, expected 0000/00000", disp, flags);
        end
        aspersao = 1'b1; gotejamento = 1'b0; nivelDagua = 3'd5;
        pulse(1'b1, 1'b0);
        ticks(93, f);
        tests_run++;
        if (disp !== 16'h0327 || flags !== 5'b10100) begin
            tests_failed++;
            $display("FAIL reset_precount: got disp=%h flags=%b, expected 0327/10100", disp, flags);
        end
        #2 resetN = 1'b0;
        #1;
        tests_run++;
        if ({disp, flags} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got disp=%h flags=%b, expected 0000/00000", disp, flags);
        end
        @(negedge clock);
        resetN = 1'b1;
        aspersao = 1'b0;
    endtask

    task automatic test_aspersao();
        int f;
        aspersao = 1'b1; gotejamento = 1'b0; casoEspecifico = 1'b0; nivelDagua = 3'd5;
        pulse(1'b1, 1'b0);
        tests_run++;
        if (disp !== 16'h0500 || flags !== 5'b10100) begin
            tests_failed++;
            $display("FAIL asp_start: got disp=%h flags=%b, expected 0500/10100", disp, flags);
        end
        ticks(1, f);
        tests_run++;
        if (disp !== 16'h0459) begin
            tests_failed++;
            $display("FAIL asp_first_tick: got %h, expected 0459", disp);
        end
        ticks(298, f);
        tests_run++;
        if (disp !== 16'h0001 || f !== 0 || flags !== 5'b10100) begin
            tests_failed++;
            $display("FAIL asp_0001: got disp=%h fims=%0d flags=%b, expected 0001/0/10100", disp, f, flags);
        end
        ticks(1, f);
        tests_run++;
        if (disp !== 16'h0000 || flags !== 5'b00010) begin
            tests_failed++;
            $display("FAIL asp_end: got disp=%h flags=%b, expected 0000/00010", disp, flags);
        end
        ticks(2, f);
        tests_run++;
        if (disp !== 16'h0000 || flags !== 5'b00000 || f !== 0) begin
            tests_failed++;
            $display("FAIL asp_after_end: got disp=%h flags=%b fims=%0d, expected 0000/00000/0", disp, flags, f);
        end
        aspersao = 1'b0;
    endtask

    task automatic test_especifico();
        int f;
        aspersao = 1'b0; gotejamento = 1'b1; casoEspecifico = 1'b1; nivelDagua = 3'd3;
        pulse(1'b1, 1'b0);
        casoEspecifico = 1'b0;
        tests_run++;
        if (disp !== 16'h0200 || flags !== 5'b01100) begin
            tests_failed++;
            $display("FAIL esp_start: got disp=%h flags=%b, expected 0200/01100", disp, flags);
        end
        ticks(60, f);
        tests_run++;
        if (disp !== 16'h0100) begin
            tests_failed++;
            $display("FAIL esp_0100: got %h, expected 0100", disp);
        end
        ticks(1, f);
        tests_run++;
        if (disp !== 16'h0059) begin
            tests_failed++;
            $display("FAIL esp_min_borrow: got %h, expected 0059", disp);
        end
        ticks(49, f);
        tests_run++;
        if (disp !== 16'h0010) begin
            tests_failed++;
            $display("FAIL esp_0010: got %h, expected 0010", disp);
        end
        ticks(1, f);
        tests_run++;
        if (disp !== 16'h0009) begin
            tests_failed++;
            $display("FAIL esp_tens_borrow: got %h, expected 0009", disp);
        end
        pulse(1'b1, 1'b0);
        tests_run++;
        if (disp !== 16'h0009 || flags !== 5'b00000) begin
            tests_failed++;
            $display("FAIL esp_abort: got disp=%h flags=%b, expected 0009/00000", disp, flags);
        end
        gotejamento = 1'b0;
    endtask

    task automatic test_invalid();
        aspersao = 1'b1; gotejamento = 1'b1; nivelDagua = 3'd5;
        pulse(1'b1, 1'b0);
        tests_run++;
        if (flags !== 5'b00000) begin
            tests_failed++;
            $display("FAIL inv_both_modes: got flags=%b, expected 00000", flags);
        end
        gotejamento = 1'b0; nivelDagua = 3'd1;
        pulse(1'b1, 1'b0);
        tests_run++;
        if (flags !== 5'b00001) begin
            tests_failed++;
            $display("FAIL inv_low_level: got flags=%b, expected 00001", flags);
        end
        pulse(1'b0, 1'b1);
        tests_run++;
        if (flags !== 5'b00001) begin
            tests_failed++;
            $display("FAIL inv_err_tick: got flags=%b, expected 00001", flags);
        end
        aspersao = 1'b0; nivelDagua = 3'd4;
        pulse(1'b1, 1'b0);
        tests_run++;
        if (flags !== 5'b00000 || disp !== 16'h0000) begin
            tests_failed++;
            $display("FAIL inv_clear: got disp=%h flags=%b, expected 0000/00000", disp, flags);
        end
    endtask

    task automatic test_falta_agua();
        int f;
        aspersao = 1'b0; gotejamento = 1'b1; casoEspecifico = 1'b0; nivelDagua = 3'd4;
        pulse(1'b1, 1'b0);
        tests_run++;
        if (disp !== 16'h1000 || flags !== 5'b01100) begin
            tests_failed++;
            $display("FAIL drip_start: got disp=%h flags=%b, expected 1000/01100", disp, flags);
        end
        // Latched drip mode must ignore a later sprinkler request with a low level.
        aspersao = 1'b1; nivelDagua = 3'd1;
        ticks(165, f);
        tests_run++;
        if (disp !== 16'h0715 || flags !== 5'b01100) begin
            tests_failed++;
            $display("FAIL drip_0715: got disp=%h flags=%b, expected 0715/01100", disp, flags);
        end
        @(negedge clock);
        nivelDagua = 3'd0;
        umSegundo  = 1'b1;
        @(negedge clock);
        umSegundo  = 1'b0;
        tests_run++;
        if (disp !== 16'h0715 || flags !== 5'b00001) begin
            tests_failed++;
            $display("FAIL drip_dry: got disp=%h flags=%b, expected 0715/00001", disp, flags);
        end
        aspersao = 1'b0; gotejamento = 1'b0; nivelDagua = 3'd4;
        pulse(1'b1, 1'b0);
        tests_run++;
        if (disp !== 16'h0000 || flags !== 5'b00000) begin
            tests_failed++;
            $display("FAIL drip_clear: got disp=%h flags=%b, expected 0000/00000", disp, flags);
        end
    endtask

    task automatic test_back_to_back();
        int f;
        aspersao = 1'b1; gotejamento = 1'b0; nivelDagua = 3'd5;
        pulse(1'b1, 1'b0);
        ticks(299, f);
        tests_run++;
        if (disp !== 16'h0001 || flags !== 5'b10100) begin
            tests_failed++;
            $display("FAIL b2b_0001: got disp=%h flags=%b, expected 0001/10100", disp, flags);
        end
        pulse(1'b1, 1'b1);
        tests_run++;
        if (disp !== 16'h0001 || flags !== 5'b00000) begin
            tests_failed++;
            $display("FAIL b2b_abort: got disp=%h flags=%b, expected 0001/00000", disp, flags);
        end
        aspersao = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        test_reset();
        test_aspersao();
        test_especifico();
        test_invalid();
        test_falta_agua();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
